// File: rtl/operand_fetch_stage_if.sv
// Bundle between the operand fetch stage and its neighbours.
//   command side  : in_valid/in_ready, rn, rm, shift, asel, bsel, sximm
//   operand side  : out_valid/out_ready, ain, bin
//   write-back    : wb_en, wb_addr, wb_data
// master = command source / ALU side, slave = operand_fetch_stage.
interface operand_fetch_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rn;
  logic [ADDR_W-1:0] rm;
  logic [1:0]        shift;
  logic              asel;
  logic              bsel;
  logic [DATA_W-1:0] sximm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, rn, rm, shift, asel, bsel, sximm, out_ready,
           wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, ain, bin
  );

  modport slave (
    input  in_valid, rn, rm, shift, asel, bsel, sximm, out_ready,
           wb_en, wb_addr, wb_data,
    output in_ready, out_valid, ain, bin
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand supply stage ahead of the 16-bit ALU.
// Holds an NREG x DATA_W register file, fetches R[rn] into latch A and
// shifted R[rm] into latch B over two cycles, then presents ain/bin with a
// valid/ready handshake. Write-back port is independent of the FSM and
// bypasses into a fetch that reads the address being written.
// Ports: clk, rst_n (async active-low), bus (operand_fetch_stage_if.slave).
module operand_fetch_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  operand_fetch_stage_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH_A = 2'd1;
  localparam logic [1:0] ST_FETCH_B = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] rn_q,        rn_d;
  logic [ADDR_W-1:0] rm_q,        rm_d;
  logic [1:0]        shift_q,     shift_d;
  logic              asel_q,      asel_d;
  logic              bsel_q,      bsel_d;
  logic [DATA_W-1:0] sximm_q,     sximm_d;
  logic [DATA_W-1:0] a_q,         a_d;
  logic [DATA_W-1:0] b_q,         b_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // B-path shifter; only ever applied to the register value, never sximm
  function automatic logic [DATA_W-1:0] shift_b(input logic [1:0] sh,
                                                input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (sh)
      2'b01:   r = {v[DATA_W-2:0], 1'b0};
      2'b10:   r = {1'b0, v[DATA_W-1:1]};
      2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Register reads with write-first bypass from the write-back port
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rn_q == ADDR_W'(i)) rd_a = regs_q[i];
      if (rm_q == ADDR_W'(i)) rd_b = regs_q[i];
    end
    if (bus.wb_en && (bus.wb_addr == rn_q)) rd_a = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == rm_q)) rd_b = bus.wb_data;
  end

  // Next-state, latch loads and write-back
  always_comb begin
    state_d   = state_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    shift_d   = shift_q;
    asel_d    = asel_q;
    bsel_d    = bsel_q;
    sximm_d   = sximm_q;
    a_d       = a_q;
    b_d       = b_q;
    regs_d    = regs_q;

    for (int i = 0; i < int'(NREG); i++) begin
      if (bus.wb_en && (bus.wb_addr == ADDR_W'(i))) regs_d[i] = bus.wb_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          rn_d    = bus.rn;
          rm_d    = bus.rm;
          shift_d = bus.shift;
          asel_d  = bus.asel;
          bsel_d  = bus.bsel;
          sximm_d = bus.sximm;
          state_d = ST_FETCH_A;
        end
      end
      ST_FETCH_A: begin
        a_d     = rd_a;
        state_d = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        b_d     = shift_b(shift_q, rd_b);
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered versions of the next state decode
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rn_q        <= '0;
      rm_q        <= '0;
      shift_q     <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      sximm_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      shift_q     <= shift_d;
      asel_q      <= asel_d;
      bsel_q      <= bsel_d;
      sximm_q     <= sximm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Operand select straight from the latches, stable while PRESENT holds
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ain       = asel_q ? '0 : a_q;
  assign bus.bin       = bsel_q ? sximm_q : b_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, fetch latency, shifts,
// selects, PRESENT hold, write-back bypass and mid-fetch reset.
module tb_operand_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  operand_fetch_stage_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  operand_fetch_stage #(.DATA_W(16), .NREG(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] addr, input logic [15:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then drives one command across the accept edge
  task automatic issue(input logic [2:0] a_rn, input logic [2:0] a_rm,
                       input logic [1:0] a_sh, input logic a_asel,
                       input logic a_bsel, input logic [15:0] a_imm);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.rn       = a_rn;
    bus.rm       = a_rm;
    bus.shift    = a_sh;
    bus.asel     = a_asel;
    bus.bsel     = a_bsel;
    bus.sximm    = a_imm;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.rn       = 3'd0;
    bus.rm       = 3'd0;
    bus.shift    = 2'b00;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.sximm    = 16'h0000;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    n_vec++;
    if (bus.ain !== 16'h0000 || bus.bin !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_ops: ain=%h bin=%h required 0000/0000", bus.ain, bus.bin);
    end
    #3 rst_n = 1'b1;
    tick();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    wb_write(3'd1, 16'h0005);
    wb_write(3'd2, 16'h0003);
    bus.out_ready = 1'b1;
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_k: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_k1: out_valid=%b required 0", bus.out_valid);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_k2: out_valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
    end
    n_vec++;
    if (bus.ain !== 16'h0005 || bus.bin !== 16'h0003) begin
      n_err++;
      $display("FAIL basic_ops: ain=%h bin=%h required 0005/0003", bus.ain, bus.bin);
    end
    consume();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_k3: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_shift();
    logic [15:0] exp_b [4];
    exp_b[0] = 16'h8002;
    exp_b[1] = 16'h0004;
    exp_b[2] = 16'h4001;
    exp_b[3] = 16'hC001;
    wb_write(3'd3, 16'h8002);
    for (int s = 0; s < 4; s++) begin
      issue(3'd1, 3'd3, 2'(s), 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.ain !== 16'h0005 || bus.bin !== exp_b[s]) begin
        n_err++;
        $display("FAIL shift_%0d: out_valid=%b ain=%h bin=%h required 1/0005/%h",
                 s, bus.out_valid, bus.ain, bus.bin, exp_b[s]);
      end
      consume();
    end
  endtask

  task automatic test_select();
    issue(3'd1, 3'd3, 2'b01, 1'b1, 1'b1, 16'hFFF0);
    tick();
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.ain !== 16'h0000 || bus.bin !== 16'hFFF0) begin
      n_err++;
      $display("FAIL select: out_valid=%b ain=%h bin=%h required 1/0000/fff0",
               bus.out_valid, bus.ain, bus.bin);
    end
    consume();
  endtask

  task automatic test_hold();
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd1;
    bus.wb_data = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.wb_en = 1'b0;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.ain !== 16'h0005 || bus.bin !== 16'h0003) begin
        n_err++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b ain=%h bin=%h required 1/0/0005/0003",
                 c, bus.out_valid, bus.in_ready, bus.ain, bus.bin);
      end
    end
    consume();
    // write during PRESENT must still have landed in the register file
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    n_vec++;
    if (bus.ain !== 16'hBEEF) begin
      n_err++;
      $display("FAIL hold_wb: ain=%h required beef", bus.ain);
    end
    consume();
  endtask

  task automatic test_bypass();
    wb_write(3'd4, 16'h1111);
    wb_write(3'd5, 16'h2222);
    wb_write(3'd6, 16'h0666);
    issue(3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd4;
    bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 1'b0;
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.ain !== 16'h1234 || bus.bin !== 16'h2222) begin
      n_err++;
      $display("FAIL bypass_a: out_valid=%b ain=%h bin=%h required 1/1234/2222",
               bus.out_valid, bus.ain, bus.bin);
    end
    consume();
    issue(3'd6, 3'd7, 2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    bus.wb_en   = 1'b1;
    bus.wb_addr = 3'd7;
    bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.ain !== 16'h0666 || bus.bin !== 16'h1234) begin
      n_err++;
      $display("FAIL bypass_b: out_valid=%b ain=%h bin=%h required 1/0666/1234",
               bus.out_valid, bus.ain, bus.bin);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.ain !== 16'h0000 || bus.bin !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b ain=%h bin=%h required 0/1/0000/0000",
               bus.out_valid, bus.in_ready, bus.ain, bus.bin);
    end
    tick();
    #2 rst_n = 1'b1;
    issue(3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.ain !== 16'h0000 || bus.bin !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_regs: out_valid=%b ain=%h bin=%h required 1/0000/0000",
               bus.out_valid, bus.ain, bus.bin);
    end
    consume();
    // rn == rm reads the same register into both latches
    wb_write(3'd1, 16'h00AA);
    issue(3'd1, 3'd1, 2'b01, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.ain !== 16'h00AA || bus.bin !== 16'h0154) begin
      n_err++;
      $display("FAIL rst_after: out_valid=%b ain=%h bin=%h required 1/00aa/0154",
               bus.out_valid, bus.ain, bus.bin);
    end
    consume();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.rn        = 3'd0;
    bus.rm        = 3'd0;
    bus.shift     = 2'b00;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.sximm     = 16'h0000;
    bus.out_ready = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 3'd0;
    bus.wb_data   = 16'h0000;
    test_reset();
    test_basic();
    test_shift();
    test_select();
    test_hold();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
